// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared data width and MEM-stage FSM state encoding
package mem_access_ctrl_pkg;
    localparam int DSIZE = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// mem_timeout_cnt: counts REQ-state cycles and flags the last one before abort
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    // Next count: clear dominates, otherwise advance while enabled
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    // Count register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expire = en & (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage req/ack data-memory controller with pipeline stall; MEM_ALIGN_CHECK_EN enables word-alignment check
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DW      = DSIZE,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic          stall_out,
    output logic [DW-1:0] rdata_out,
    output logic          rdata_valid,
    output logic          err_out,
    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata
);
    state_t        state_q, state_d;
    logic          req_q, req_d, we_q, we_d, valid_q, valid_d, err_q, err_d;
    logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          req_any, req_bad, start, in_req, done_ok, abort, expire;

    assign req_any = mem_read_in | mem_write_in;
`ifdef MEM_ALIGN_CHECK_EN
    assign req_bad = (mem_read_in & mem_write_in) | (req_any & (addr_in[1:0] != 2'b00));
`else
    assign req_bad = mem_read_in & mem_write_in;
`endif
    assign in_req    = state_q == REQ;
    assign start     = (state_q == IDLE) & req_any & ~req_bad;
    assign done_ok   = in_req & dm_ack;
    assign abort     = in_req & ~dm_ack & expire;
    assign stall_out = in_req | ((state_q == IDLE) & req_any);

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (~in_req),
        .en     (in_req),
        .expire (expire)
    );

    // Next state and registered outputs; DONE always returns to IDLE so ops are separated by a bubble
    always_comb begin
        state_d = (state_q == IDLE) ? (req_bad ? DONE : req_any ? REQ : IDLE)
                : in_req ? ((dm_ack | expire) ? DONE : REQ) : IDLE;
        req_d   = state_d == REQ;
        we_d    = start ? mem_write_in : we_q;
        addr_d  = start ? addr_in : addr_q;
        wdata_d = start ? wdata_in : wdata_q;
        rdata_d = (done_ok & ~we_q) ? dm_rdata : abort ? '0 : rdata_q;
        valid_d = done_ok & ~we_q;
        err_d   = ((state_q == IDLE) & req_bad) | abort;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dm_req      = req_q;
    assign dm_we       = we_q;
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign rdata_out   = rdata_q;
    assign rdata_valid = valid_q;
    assign err_out     = err_q;
endmodule
